// File: rtl/keypad_scan.sv
// 4x4 keypad matrix scanner: drives one column low at a time, synchronizes and
// debounces the active-low row returns, and reports one registered key event per press.
module keypad_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  logic [3:0]       rowMeta_q;
  logic [3:0]       rowSync_q;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [1:0]       colIdx_q, colIdx_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] debCnt_q, debCnt_d;
  logic [3:0]       keyCode_q, keyCode_d;
  logic             keyValid_q, keyValid_d;
  logic             keyHeld_q, keyHeld_d;

  logic             tick;
  logic             rowValid;
  logic [1:0]       rowIdx;
  logic [CNT_W-1:0] debInc;

  // Row returns are asynchronous to clk, so they only enter the logic through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= row_in;
      rowSync_q <= rowMeta_q;
    end
  end

  assign tick   = (divCnt_q == DIV_LAST);
  assign divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
  assign debInc = debCnt_q + CNT_W'(1);

  // A sample is a key only when exactly one row is pulled low; ghosting patterns are ignored.
  always_comb begin
    rowValid = 1'b0;
    rowIdx   = 2'd0;
    case (rowSync_q)
      4'b1110: begin rowValid = 1'b1; rowIdx = 2'd0; end
      4'b1101: begin rowValid = 1'b1; rowIdx = 2'd1; end
      4'b1011: begin rowValid = 1'b1; rowIdx = 2'd2; end
      4'b0111: begin rowValid = 1'b1; rowIdx = 2'd3; end
      default: begin rowValid = 1'b0; rowIdx = 2'd0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    colIdx_d   = colIdx_q;
    cand_d     = cand_q;
    debCnt_d   = debCnt_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rowValid) begin
            cand_d   = {rowIdx, colIdx_q};
            debCnt_d = CNT_W'(1);
            state_d  = DEBOUNCE;
          end else begin
            colIdx_d = colIdx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rowValid && ({rowIdx, colIdx_q} == cand_q)) begin
            if (debInc == CNT_LAST) begin
              keyCode_d  = cand_q;
              keyValid_d = 1'b1;
              keyHeld_d  = 1'b1;
              debCnt_d   = '0;
              state_d    = HELD;
            end else begin
              debCnt_d = debInc;
            end
          end else begin
            debCnt_d = '0;
            colIdx_d = colIdx_q + 2'd1;
            state_d  = SCAN;
          end
        end
        HELD: begin
          // Column stays frozen so only the held key's column is ever observed here.
          if (rowSync_q == 4'hF) begin
            if (debInc == CNT_LAST) begin
              keyHeld_d = 1'b0;
              debCnt_d  = '0;
              colIdx_d  = colIdx_q + 2'd1;
              state_d   = SCAN;
            end else begin
              debCnt_d = debInc;
            end
          end else begin
            debCnt_d = '0;
          end
        end
        default: begin
          debCnt_d = '0;
          state_d  = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt_q   <= '0;
      colIdx_q   <= 2'd0;
      state_q    <= SCAN;
      cand_q     <= 4'h0;
      debCnt_q   <= '0;
      keyCode_q  <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      divCnt_q   <= divCnt_d;
      colIdx_q   <= colIdx_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      debCnt_q   <= debCnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

  assign col_out   = ~(4'b0001 << colIdx_q);
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model pulls a row low only while its
// column is driven, and each scenario task checks hand-computed cycle timing.
module tb_keypad_scan;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       keyDown;
  logic [1:0] keyCol;
  logic [3:0] keyMask;

  int total;
  int bad;

  keypad_scan #(
    .SCAN_DIV(4),
    .DEB_CNT (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: the pressed switch connects its row to its column only while that column is low.
  assign row_in = (keyDown && (col_out == ~(4'b0001 << keyCol))) ? keyMask : 4'hF;

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] expCol [4];
    expCol[0] = 4'b1101;
    expCol[1] = 4'b1011;
    expCol[2] = 4'b0111;
    expCol[3] = 4'b1110;
    keyDown = 1'b0;
    keyCol  = 2'd0;
    keyMask = 4'hF;
    rst     = 1'b0;
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL reset_col got=%b exp=1110", col_out); end
    total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL reset_code got=%h exp=0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL reset_held got=%b exp=0", key_held); end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int c = 1; c <= 4; c++) begin
        stepCycle();
        if (t == 0 && c == 3) begin
          total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL first_tick_early got=%b exp=1110", col_out); end
        end
        total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL scan_valid t=%0d c=%0d got=%b exp=0", t, c, key_valid); end
      end
      total++; if (col_out !== expCol[t]) begin bad++; $display("[TB] FAIL scan_col t=%0d got=%b exp=%b", t, col_out, expCol[t]); end
    end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL scan_held got=%b exp=0", key_held); end
    total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL scan_code got=%h exp=0", key_code); end
  endtask

  task automatic test_press();
    int pulses;
    int pulseAt;
    pulses  = 0;
    pulseAt = -1;
    keyCol  = 2'd1;
    keyMask = 4'b1011;
    keyDown = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      stepCycle();
      if (key_valid === 1'b1) begin pulses++; pulseAt = c; end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL press_pulses got=%0d exp=1", pulses); end
    total++; if (pulseAt !== 16) begin bad++; $display("[TB] FAIL press_latency got=%0d exp=16", pulseAt); end
    total++; if (key_code !== 4'h9) begin bad++; $display("[TB] FAIL press_code got=%h exp=9", key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL press_held got=%b exp=1", key_held); end
    total++; if (col_out !== 4'b1101) begin bad++; $display("[TB] FAIL press_frozen got=%b exp=1101", col_out); end
  endtask

  task automatic test_release();
    int fallAt;
    int pulses;
    fallAt  = -1;
    pulses  = 0;
    keyDown = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      if (key_valid === 1'b1) pulses++;
      if (fallAt < 0 && key_held === 1'b0) fallAt = c;
    end
    total++; if (fallAt !== 12) begin bad++; $display("[TB] FAIL release_time got=%0d exp=12", fallAt); end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL release_pulses got=%0d exp=0", pulses); end
    total++; if (col_out !== 4'b1011) begin bad++; $display("[TB] FAIL release_col got=%b exp=1011", col_out); end
    total++; if (key_code !== 4'h9) begin bad++; $display("[TB] FAIL release_code got=%h exp=9", key_code); end
  endtask

  task automatic test_repress();
    int pulses;
    int pulseAt;
    pulses  = 0;
    pulseAt = -1;
    keyCol  = 2'd1;
    keyMask = 4'b1011;
    keyDown = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      stepCycle();
      if (key_valid === 1'b1) begin pulses++; pulseAt = c; end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL repress_pulses got=%0d exp=1", pulses); end
    total++; if (pulseAt !== 24) begin bad++; $display("[TB] FAIL repress_latency got=%0d exp=24", pulseAt); end
    total++; if (key_code !== 4'h9) begin bad++; $display("[TB] FAIL repress_code got=%h exp=9", key_code); end
    keyDown = 1'b0;
    for (int c = 1; c <= 12; c++) stepCycle();
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL repress_release got=%b exp=0", key_held); end
    total++; if (col_out !== 4'b1011) begin bad++; $display("[TB] FAIL repress_col got=%b exp=1011", col_out); end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses  = 0;
    keyCol  = 2'd3;
    keyMask = 4'b1011;
    keyDown = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      if (key_valid === 1'b1) pulses++;
    end
    total++; if (col_out !== 4'b0111) begin bad++; $display("[TB] FAIL bounce_hold_col got=%b exp=0111", col_out); end
    keyDown = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      if (key_valid === 1'b1) pulses++;
    end
    total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL bounce_col got=%b exp=1110", col_out); end
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      if (key_valid === 1'b1) pulses++;
    end
    total++; if (col_out !== 4'b1101) begin bad++; $display("[TB] FAIL bounce_rescan got=%b exp=1101", col_out); end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL bounce_pulses got=%0d exp=0", pulses); end
    total++; if (key_code !== 4'h9) begin bad++; $display("[TB] FAIL bounce_code got=%h exp=9", key_code); end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL bounce_held got=%b exp=0", key_held); end
  endtask

  task automatic test_ghost();
    int pulses;
    pulses  = 0;
    keyCol  = 2'd0;
    keyMask = 4'b1001;
    keyDown = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      stepCycle();
      if (key_valid === 1'b1) pulses++;
      if (c == 12) begin
        total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL ghost_col0 got=%b exp=1110", col_out); end
      end
    end
    total++; if (col_out !== 4'b1101) begin bad++; $display("[TB] FAIL ghost_advance got=%b exp=1101", col_out); end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL ghost_pulses got=%0d exp=0", pulses); end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL ghost_held got=%b exp=0", key_held); end
    keyDown = 1'b0;
  endtask

  task automatic test_async_reset();
    int pulses;
    int pulseAt;
    pulses  = 0;
    pulseAt = -1;
    keyCol  = 2'd2;
    keyMask = 4'b1110;
    keyDown = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      stepCycle();
      if (key_valid === 1'b1) begin pulses++; pulseAt = c; end
    end
    total++; if (pulseAt !== 16 || pulses !== 1) begin bad++; $display("[TB] FAIL held_pulse got=%0d/%0d exp=16/1", pulseAt, pulses); end
    total++; if (key_code !== 4'h2) begin bad++; $display("[TB] FAIL held_code got=%h exp=2", key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("[TB] FAIL held_state got=%b exp=1", key_held); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL areset_col got=%b exp=1110", col_out); end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL areset_held got=%b exp=0", key_held); end
    total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL areset_code got=%h exp=0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL areset_valid got=%b exp=0", key_valid); end
    keyDown = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      if (c == 3) begin
        total++; if (col_out !== 4'b1110) begin bad++; $display("[TB] FAIL restart_early got=%b exp=1110", col_out); end
      end
    end
    total++; if (col_out !== 4'b1101) begin bad++; $display("[TB] FAIL restart_tick got=%b exp=1101", col_out); end
    total++; if (key_held !== 1'b0) begin bad++; $display("[TB] FAIL restart_held got=%b exp=0", key_held); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_press();
    test_release();
    test_repress();
    test_bounce();
    test_ghost();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
